// File: rtl/dmg_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dmg_timer
//  Description : DMG DIV/TIMA/TMA/TAC timer. A 16-bit free-running system
//                counter feeds a selectable falling-edge detector that clocks
//                an 8-bit reloadable counter. Overflow opens a short reload
//                window that ends with a TMA reload and a one-clk irq pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmg_timer #(
    parameter int RELOAD_DELAY = 4
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       sel,
    input  logic [1:0] addr,
    input  logic       wr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq
);

    localparam logic [1:0] ADDR_DIV  = 2'd0;
    localparam logic [1:0] ADDR_TIMA = 2'd1;
    localparam logic [1:0] ADDR_TMA  = 2'd2;
    localparam logic [1:0] ADDR_TAC  = 2'd3;

    localparam logic [3:0] OVF_LOAD  = 4'(RELOAD_DELAY);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_RELOAD  = 2'd2
    } state_t;

    // Architectural state
    logic [15:0] sys_cnt;
    logic [7:0]  tima;
    logic [7:0]  tma;
    logic [2:0]  tac;
    logic        tick_prev;
    logic [3:0]  ovf_cnt;
    state_t      state;

    // Next-state values
    logic [15:0] sys_next;
    logic [7:0]  tima_next;
    logic [7:0]  tma_next;
    logic [2:0]  tac_next;
    logic [3:0]  ovf_next;
    state_t      state_next;
    logic        irq_next;

    // Decoded writes and edge detection
    logic        div_wr;
    logic        tima_wr;
    logic        tma_wr;
    logic        tac_wr;
    logic        sel_bit;
    logic        tick_in;
    logic        tick_fall;

    // Decode register writes and derive the post-edge counter/TAC values the
    // edge detector must see, so DIV writes and TAC changes glitch TIMA.
    always_comb begin
        div_wr   = sel & wr & (addr == ADDR_DIV);
        tima_wr  = sel & wr & (addr == ADDR_TIMA);
        tma_wr   = sel & wr & (addr == ADDR_TMA);
        tac_wr   = sel & wr & (addr == ADDR_TAC);

        sys_next = div_wr ? 16'h0000 : sys_cnt + 16'h0001;
        tac_next = tac_wr ? wdata[2:0] : tac;
        tma_next = tma_wr ? wdata : tma;

        sel_bit  = 1'b0;
        case (tac_next[1:0])
            2'b00:   sel_bit = sys_next[9];
            2'b01:   sel_bit = sys_next[3];
            2'b10:   sel_bit = sys_next[5];
            default: sel_bit = sys_next[7];
        endcase

        tick_in   = tac_next[2] & sel_bit;
        tick_fall = tick_prev & ~tick_in;
    end

    // Reload-window FSM next state together with TIMA update and irq.
    always_comb begin
        state_next = state;
        tima_next  = tima;
        ovf_next   = ovf_cnt;
        irq_next   = 1'b0;

        case (state)
            ST_IDLE: begin
                // A CPU write beats a coincident tick; the increment is lost.
                if (tima_wr) begin
                    tima_next = wdata;
                end else if (tick_fall) begin
                    if (tima == 8'hFF) begin
                        tima_next  = 8'h00;
                        ovf_next   = OVF_LOAD;
                        state_next = ST_PENDING;
                    end else begin
                        tima_next = tima + 8'h01;
                    end
                end
            end

            ST_PENDING: begin
                if (tima_wr) begin
                    // Writing TIMA cancels the pending reload and its irq.
                    tima_next  = wdata;
                    ovf_next   = 4'd0;
                    state_next = ST_IDLE;
                end else if (ovf_cnt <= 4'd1) begin
                    // Take the forwarded TMA so a same-edge TMA write is seen.
                    tima_next  = tma_next;
                    irq_next   = 1'b1;
                    ovf_next   = 4'd0;
                    state_next = ST_RELOAD;
                end else begin
                    ovf_next = ovf_cnt - 4'd1;
                    if (tick_fall) begin
                        tima_next = tima + 8'h01;
                    end
                end
            end

            ST_RELOAD: begin
                // TIMA writes are dropped here; TMA writes pass straight through.
                state_next = ST_IDLE;
                if (tma_wr) begin
                    tima_next = wdata;
                end else if (tick_fall) begin
                    tima_next = tima + 8'h01;
                end
            end

            default: begin
                state_next = ST_IDLE;
                ovf_next   = 4'd0;
            end
        endcase
    end

    // Counter, registers, edge history and FSM state; async active-low reset.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sys_cnt   <= 16'h0000;
            tima      <= 8'h00;
            tma       <= 8'h00;
            tac       <= 3'b000;
            tick_prev <= 1'b0;
            ovf_cnt   <= 4'd0;
            state     <= ST_IDLE;
            irq       <= 1'b0;
        end else begin
            sys_cnt   <= sys_next;
            tima      <= tima_next;
            tma       <= tma_next;
            tac       <= tac_next;
            tick_prev <= tick_in;
            ovf_cnt   <= ovf_next;
            state     <= state_next;
            irq       <= irq_next;
        end
    end

    // Combinational register read; unselected block floats the bus high.
    always_comb begin
        rdata = 8'hFF;
        if (sel) begin
            case (addr)
                ADDR_DIV:  rdata = sys_cnt[15:8];
                ADDR_TIMA: rdata = tima;
                ADDR_TMA:  rdata = tma;
                ADDR_TAC:  rdata = {5'b11111, tac};
                default:   rdata = 8'hFF;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmg_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmg_timer
//  Description : Directed self-checking bench for dmg_timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmg_timer;

    logic       clk;
    logic       nreset;
    logic       sel;
    logic [1:0] addr;
    logic       wr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       irq;

    int total;
    int bad;
    int irq_count;

    dmg_timer #(.RELOAD_DELAY(4)) dut (
        .clk    (clk),
        .nreset (nreset),
        .sel    (sel),
        .addr   (addr),
        .wr     (wr),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count irq-high clocks, sampled on the falling edge.
    always @(negedge clk) begin
        if (irq === 1'b1) irq_count++;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; return positioned on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        sel  = 1'b1;
        wr   = 1'b0;
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        sel   = 1'b1;
        wr    = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        @(negedge clk);
        wr = 1'b0;
    endtask

    // Step until TIMA reads v, bounded; one comparison either way.
    task automatic wait_tima(input string tag, input logic [7:0] v);
        logic [7:0] d;
        int n;
        n = 0;
        rd(2'd1, d);
        while (d !== v && n < 64) begin
            step();
            n++;
            rd(2'd1, d);
        end
        check(tag, {8'h00, d}, {8'h00, v});
    endtask

    // Arm an overflow from 0xFE and stop on the first PENDING clk.
    task automatic arm_overflow(input logic [7:0] tma_v);
        wr_reg(2'd3, 8'h05);
        wr_reg(2'd2, tma_v);
        wr_reg(2'd1, 8'hFE);
        wait_tima("reach_ff", 8'hFF);
        wait_tima("reach_00", 8'h00);
    endtask

    initial begin
        logic [7:0] d;
        int snap;

        total     = 0;
        bad       = 0;
        irq_count = 0;
        nreset    = 1'b0;
        sel       = 1'b0;
        wr        = 1'b0;
        addr      = 2'd0;
        wdata     = 8'h00;

        // Reset state
        #2;
        check("rd_unsel", {8'h00, rdata}, 16'h00FF);
        rd(2'd0, d); check("rst_div",  {8'h00, d}, 16'h0000);
        rd(2'd1, d); check("rst_tima", {8'h00, d}, 16'h0000);
        rd(2'd3, d); check("rst_tac",  {8'h00, d}, 16'h00F8);
        check("rst_irq", {15'h0, irq}, 16'h0000);

        // DIV rate: 256 clks per increment, TAC disabled keeps TIMA at 0
        @(negedge clk);
        nreset = 1'b1;
        steps(255);
        rd(2'd0, d); check("div_255", {8'h00, d}, 16'h0000);
        step();
        rd(2'd0, d); check("div_256", {8'h00, d}, 16'h0001);
        steps(768);
        rd(2'd0, d); check("div_1024", {8'h00, d}, 16'h0004);
        rd(2'd1, d); check("tima_dis", {8'h00, d}, 16'h0000);
        check("irq_none", 16'(irq_count), 16'h0000);

        // Full overflow: 0x00 for 4 clks, then TMA with a one-clk irq
        snap = irq_count;
        arm_overflow(8'hF0);
        check("pend_irq0", {15'h0, irq}, 16'h0000);
        for (int k = 1; k <= 3; k++) begin
            step();
            rd(2'd1, d); check("pend_zero", {8'h00, d}, 16'h0000);
            check("pend_irq", {15'h0, irq}, 16'h0000);
        end
        step();
        rd(2'd1, d); check("reload_tima", {8'h00, d}, 16'h00F0);
        check("reload_irq", {15'h0, irq}, 16'h0001);
        step();
        check("irq_drop", {15'h0, irq}, 16'h0000);
        rd(2'd1, d); check("post_tima", {8'h00, d}, 16'h00F0);
        check("irq_once", 16'(irq_count - snap), 16'h0001);

        // TIMA write in the 2nd PENDING clk aborts the reload
        arm_overflow(8'hF0);
        step();
        snap = irq_count;
        wr_reg(2'd1, 8'h33);
        steps(6);
        rd(2'd1, d); check("abort_tima", {8'h00, d}, 16'h0033);
        check("abort_noirq", 16'(irq_count - snap), 16'h0000);

        // TMA write in the RELOAD clk is forwarded into TIMA
        arm_overflow(8'hF0);
        snap = irq_count;
        steps(4);
        wr_reg(2'd2, 8'h77);
        rd(2'd1, d); check("fwd_tima", {8'h00, d}, 16'h0077);
        rd(2'd2, d); check("fwd_tma",  {8'h00, d}, 16'h0077);
        check("fwd_irq", 16'(irq_count - snap), 16'h0001);

        // TIMA write in the RELOAD clk is ignored
        arm_overflow(8'h77);
        steps(4);
        wr_reg(2'd1, 8'h12);
        rd(2'd1, d); check("ign_tima", {8'h00, d}, 16'h0077);

        // DIV write while sys_cnt[3]=1 glitches TIMA up by one
        wr_reg(2'd0, 8'hAB);
        wr_reg(2'd1, 8'h10);
        steps(7);
        wr_reg(2'd0, 8'h00);
        rd(2'd1, d); check("div_glitch", {8'h00, d}, 16'h0011);
        rd(2'd0, d); check("div_clear",  {8'h00, d}, 16'h0000);

        // Disabling TAC while bit 3 is high also glitches TIMA
        steps(8);
        wr_reg(2'd3, 8'h01);
        rd(2'd1, d); check("tac_glitch", {8'h00, d}, 16'h0012);
        rd(2'd3, d); check("tac_read",   {8'h00, d}, 16'h00F9);

        // Reset in PENDING discards the window
        arm_overflow(8'hF0);
        step();
        nreset = 1'b0;
        #1;
        rd(2'd1, d); check("arst_tima", {8'h00, d}, 16'h0000);
        rd(2'd0, d); check("arst_div",  {8'h00, d}, 16'h0000);
        check("arst_irq", {15'h0, irq}, 16'h0000);
        steps(2);
        nreset = 1'b1;
        snap = irq_count;
        steps(10);
        check("arst_noirq", 16'(irq_count - snap), 16'h0000);
        rd(2'd1, d); check("arst_tima2", {8'h00, d}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
